// File: rtl/pipe_add_seg_pkg.sv
// pipe_add_seg_pkg: shared constants and helpers for the segmented pipelined
// adder family (also used by the multiplier top so both agree on SEG_W and
// pipeline depth).
// Optional feature macro: PIPE_ADD_SAT_EN (saturate sum to all ones on carry out).

// True when W is a legal operand width for segment width S.
`ifndef PIPE_ADD_WIDTH_OK
`define PIPE_ADD_WIDTH_OK(W, S) (((S) > 0) && ((W) >= (S)) && (((W) % (S)) == 0))
`endif

package pipe_add_seg_pkg;

  // Default segment width added per pipeline stage.
  localparam int unsigned SEG_W_DEF = 4;

  // Overflow handling of the final stage.
  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

`ifdef PIPE_ADD_SAT_EN
  localparam ovf_mode_e OVF_MODE = OVF_SAT;
`else
  localparam ovf_mode_e OVF_MODE = OVF_WRAP;
`endif

  // Pipeline depth: one stage per segment.
  function automatic int unsigned stages_f(input int unsigned width,
                                           input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/pipe_add_seg_add_seg.sv
// add_seg: combinational SEG_W-bit unsigned adder with carry in / carry out.
// One instance per pipeline stage of pipe_add_seg.

module add_seg
  import pipe_add_seg_pkg::*;
#(
  parameter int unsigned SEG_W = SEG_W_DEF
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic [SEG_W-1:0] s_o,
  output logic             c_o
);

  logic [SEG_W:0] full;

  // Widen to SEG_W+1 so the carry lands in the top bit.
  always_comb begin
    full = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, c_i};
    s_o  = full[SEG_W-1:0];
    c_o  = full[SEG_W];
  end

endmodule

// File: rtl/pipe_add_seg.sv
// pipe_add_seg: parametrised segmented pipelined unsigned adder.
// A WIDTH-bit add is split into STAGES = WIDTH/SEG_W segments, one per stage;
// the carry ripples through stage registers. A single global enable
// (en = !out_valid || out_ready) advances or freezes the whole pipeline, so
// backpressure holds every stage and the output registers stable.
// Optional feature macro: PIPE_ADD_SAT_EN (see pipe_add_seg_pkg).

module pipe_add_seg
  import pipe_add_seg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = stages_f(WIDTH, SEG_W);
  localparam int unsigned LAST   = STAGES - 1;

  if (!(`PIPE_ADD_WIDTH_OK(WIDTH, SEG_W))) begin : g_cfg_check
    $error("pipe_add_seg: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic              en;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Per-stage data registers. Operands are kept shifted so the next segment
  // to add always sits in the low SEG_W bits; the partial sum is built from
  // the top down, so after STAGES shifts segment 0 lands at bit 0.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];

  // Stage inputs: the previous stage's registers, or the ports for stage 0.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic              src_c [STAGES];

  // Stage next-state values.
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];

  logic [SEG_W-1:0]  seg_s [STAGES];
  logic              seg_c [STAGES];

  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_q;
  logic              cout_d;
  logic              ovf_q;
  logic              ovf_d;

  // Global pipeline enable; the input side is ready whenever the pipe moves.
  always_comb begin
    en       = !valid_q[LAST] || out_ready;
    in_ready = en;
  end

  // Select each stage's operands: ports feed stage 0, registers feed the rest.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      src_a[k] = '0;
      src_b[k] = '0;
      src_s[k] = '0;
      src_c[k] = 1'b0;
    end
    src_a[0] = a;
    src_b[0] = b;
    src_c[0] = cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  // One segment adder per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_seg #(
      .SEG_W (SEG_W)
    ) u_add_seg (
      .a_i (src_a[k][SEG_W-1:0]),
      .b_i (src_b[k][SEG_W-1:0]),
      .c_i (src_c[k]),
      .s_o (seg_s[k]),
      .c_o (seg_c[k])
    );
  end

  // Consume the low segment of each operand and insert the new partial sum
  // at the top of the skew-aligned result.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_d[k] = src_a[k] >> SEG_W;
      b_d[k] = src_b[k] >> SEG_W;
      s_d[k] = src_s[k] >> SEG_W;
      s_d[k][WIDTH-1 -: SEG_W] = seg_s[k];
    end
  end

  // Final-stage result, with optional saturation on carry out.
  always_comb begin
    cout_d = seg_c[LAST];
    ovf_d  = seg_c[LAST];
    sum_d  = s_d[LAST];
    if ((OVF_MODE == OVF_SAT) && seg_c[LAST]) begin
      sum_d = '1;
    end
  end

  // Valid shift: a new beat enters stage 0 whenever the pipe advances.
  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = in_valid;
  end

  // Stage data registers; content of invalid stages is don't-care, no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= seg_c[k];
      end
    end
  end

  // Valid bits and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    out_valid = valid_q[LAST];
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_pipe_add_seg.sv
// tb_pipe_add_seg: self-checking bench for pipe_add_seg (WIDTH=16, SEG_W=4).
// A delay-line reference model computes a+b+cin arithmetically and is checked
// against the DUT every cycle; directed sequences pin literal expectations.

module tb_pipe_add_seg;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned ST = W / SW;

`ifdef PIPE_ADD_SAT_EN
  localparam logic [W-1:0] RIPPLE_SUM = 16'hFFFF;
`else
  localparam logic [W-1:0] RIPPLE_SUM = 16'h0000;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Reference model: ST-deep delay line of {valid, full (W+1)-bit result}.
  logic       m_v [ST];
  logic [W:0] m_r [ST];

  // Handshaken results observed at the output, with their cycle stamps.
  logic [W:0]  got_q [$];
  int unsigned got_c [$];

  pipe_add_seg #(
    .WIDTH (W),
    .SEG_W (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] exp_sum(input logic [W:0] r);
`ifdef PIPE_ADD_SAT_EN
    return r[W] ? '1 : r[W-1:0];
`else
    return r[W-1:0];
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ST; k++) m_v[k] <= 1'b0;
    end else if (!m_v[ST-1] || out_ready) begin
      for (int k = ST - 1; k > 0; k--) begin
        m_v[k] <= m_v[k-1];
        m_r[k] <= m_r[k-1];
      end
      m_v[0] <= in_valid;
      m_r[0] <= ref_add(a, b, cin);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_out_valid", out_valid, m_v[ST-1]);
    chk("model_in_ready", in_ready, !m_v[ST-1] || out_ready);
    if (m_v[ST-1]) begin
      chk("model_sum", sum, exp_sum(m_r[ST-1]));
      chk("model_cout", cout, m_r[ST-1][W]);
      chk("model_ovf", ovf, m_r[ST-1][W]);
    end
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({cout, sum});
      got_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_c.delete();
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk(name, got_q.size(), n);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // Basic beat with exact latency.
    drive(1'b1, 16'h1234, 16'h1111, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("basic_not_early", out_valid, 0);
    tick();
    chk("basic_valid", out_valid, 1);
    chk("basic_sum", sum, 16'h2345);
    chk("basic_cout", cout, 0);
    chk("basic_ovf", ovf, 0);

    // Full carry ripple through every segment.
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    chk("ripple_valid", out_valid, 1);
    chk("ripple_sum", sum, RIPPLE_SUM);
    chk("ripple_cout", cout, 1);
    chk("ripple_ovf", ovf, 1);
    repeat (3) tick();

    // Back-to-back beats: in order, no gaps.
    clear_got();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'(i), 16'h00FF, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    wait_got(8, 20, "b2b_count");
    if (got_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b_value", got_q[i], {1'b0, 16'h00FF + W'(i)});
        chk("b2b_no_gap", got_c[i] - got_c[0], i);
      end
    end
    repeat (2) tick();

    // Backpressure: stall 3 cycles with a result valid, then drain.
    clear_got();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0100 + W'(i), 16'h0010, 1'b0);
      tick();
    end
    out_ready = 1'b0;
    drive(1'b1, 16'h0200, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid_held", out_valid, 1);
      chk("bp_sum_stable", sum, 16'h0110);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    wait_got(5, 20, "bp_count");
    if (got_q.size() >= 5) begin
      for (int i = 0; i < 4; i++) chk("bp_order", got_q[i], {1'b0, 16'h0110 + W'(i)});
      chk("bp_late_beat", got_q[4], {1'b0, 16'h0210});
    end
    repeat (2) tick();

    // Reset with beats in flight.
    clear_got();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h3000 + W'(i), 16'h0001, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("mid_rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_sum", sum, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_flushed", out_valid, 0);
    drive(1'b1, 16'h0ABC, 16'h0101, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("post_rst_not_early", out_valid, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_sum", sum, 16'h0BBE);
    tick();
    chk("post_rst_only_new", got_q.size(), 1);
    if (got_q.size() >= 1) chk("post_rst_value", got_q[0], {1'b0, 16'h0BBE});
    tick();

    // Bubbles: alternate valid, outputs alternate too.
    clear_got();
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 16'h0F00 + W'(i), 16'h00F0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    wait_got(4, 20, "bubble_count");
    if (got_q.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("bubble_value", got_q[j], {1'b0, 16'h0FF0 + W'(2 * j)});
        if (j > 0) chk("bubble_spacing", got_c[j] - got_c[j-1], 2);
      end
    end
    repeat (2) tick();

    // Randomised traffic with random backpressure, checked by the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a   = (($urandom % 4) == 0) ? (16'hFFFF - W'($urandom % 4)) : W'($urandom);
      b   = (($urandom % 4) == 0) ? W'($urandom % 4) : W'($urandom);
      cin = 1'($urandom);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
